// File: rtl/operand_read_stage_if.sv
// Decode/register-file/execute bundle for the operand read stage.
// The stage itself uses the slave modport; its environment uses master.
interface operand_read_stage_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
);
  logic              InValid;
  logic              InReady;
  logic [ADDR_W-1:0] SrcReg1;
  logic [ADDR_W-1:0] SrcReg2;
  logic [ADDR_W-1:0] RfAddr1;
  logic [ADDR_W-1:0] RfAddr2;
  logic [DATA_W-1:0] RfData1;
  logic [DATA_W-1:0] RfData2;
  logic              WbEnable;
  logic [ADDR_W-1:0] WbReg;
  logic [DATA_W-1:0] WbData;
  logic              Flush;
  logic              OutValid;
  logic              OutReady;
  logic [DATA_W-1:0] Op1;
  logic [DATA_W-1:0] Op2;
  logic [ADDR_W-1:0] OutSrc1;
  logic [ADDR_W-1:0] OutSrc2;

  modport slave (
    input  InValid, SrcReg1, SrcReg2, RfData1, RfData2,
           WbEnable, WbReg, WbData, Flush, OutReady,
    output InReady, RfAddr1, RfAddr2, OutValid, Op1, Op2, OutSrc1, OutSrc2
  );

  modport master (
    output InValid, SrcReg1, SrcReg2, RfData1, RfData2,
           WbEnable, WbReg, WbData, Flush, OutReady,
    input  InReady, RfAddr1, RfAddr2, OutValid, Op1, Op2, OutSrc1, OutSrc2
  );
endinterface

// File: rtl/operand_read_stage.sv
// Register-file read stage with a 2-entry skid buffer and writeback bypass.
// Define OPERAND_REFRESH_EN to keep held operands up to date with later writebacks.
module operand_read_stage #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input logic                clk,
  input logic                rst,
  operand_read_stage_if.slave bus
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t            state, state_nx;
  logic              in_ready_q;
  logic              accept, pop;

  logic [DATA_W-1:0] head_op1, head_op2, skid_op1, skid_op2;
  logic [ADDR_W-1:0] head_src1, head_src2, skid_src1, skid_src2;
  logic [DATA_W-1:0] head_op1_nx, head_op2_nx, skid_op1_nx, skid_op2_nx;
  logic [ADDR_W-1:0] head_src1_nx, head_src2_nx, skid_src1_nx, skid_src2_nx;
  logic [DATA_W-1:0] head_r1, head_r2, skid_r1, skid_r2;
  logic [DATA_W-1:0] cap_op1, cap_op2;

  // R0 reads as zero; a same-cycle writeback to the source wins over the array.
  function automatic logic [DATA_W-1:0] capture(
    input logic [ADDR_W-1:0] src,
    input logic [DATA_W-1:0] rf,
    input logic              wbe,
    input logic [ADDR_W-1:0] wbr,
    input logic [DATA_W-1:0] wbd
  );
    if (src == '0)
      return '0;
    else if (wbe && (wbr == src))
      return wbd;
    else
      return rf;
  endfunction

  assign accept = bus.InValid & in_ready_q;
  assign pop    = bus.OutValid & bus.OutReady;

  assign cap_op1 = capture(bus.SrcReg1, bus.RfData1, bus.WbEnable, bus.WbReg, bus.WbData);
  assign cap_op2 = capture(bus.SrcReg2, bus.RfData2, bus.WbEnable, bus.WbReg, bus.WbData);

`ifdef OPERAND_REFRESH_EN
  assign head_r1 = (head_src1 != '0 && bus.WbEnable && bus.WbReg == head_src1) ? bus.WbData : head_op1;
  assign head_r2 = (head_src2 != '0 && bus.WbEnable && bus.WbReg == head_src2) ? bus.WbData : head_op2;
  assign skid_r1 = (skid_src1 != '0 && bus.WbEnable && bus.WbReg == skid_src1) ? bus.WbData : skid_op1;
  assign skid_r2 = (skid_src2 != '0 && bus.WbEnable && bus.WbReg == skid_src2) ? bus.WbData : skid_op2;
`else
  assign head_r1 = head_op1;
  assign head_r2 = head_op2;
  assign skid_r1 = skid_op1;
  assign skid_r2 = skid_op2;
`endif

  // Held entries default to their (possibly refreshed) contents; a pop from TWO
  // promotes the refreshed skid so a write landing that cycle is not lost.
  always_comb begin
    state_nx     = state;
    head_op1_nx  = head_r1;
    head_op2_nx  = head_r2;
    head_src1_nx = head_src1;
    head_src2_nx = head_src2;
    skid_op1_nx  = skid_r1;
    skid_op2_nx  = skid_r2;
    skid_src1_nx = skid_src1;
    skid_src2_nx = skid_src2;
    if (bus.Flush) begin
      state_nx = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state_nx     = ONE;
            head_op1_nx  = cap_op1;
            head_op2_nx  = cap_op2;
            head_src1_nx = bus.SrcReg1;
            head_src2_nx = bus.SrcReg2;
          end
        end
        ONE: begin
          if (accept && !pop) begin
            state_nx     = TWO;
            skid_op1_nx  = cap_op1;
            skid_op2_nx  = cap_op2;
            skid_src1_nx = bus.SrcReg1;
            skid_src2_nx = bus.SrcReg2;
          end else if (accept && pop) begin
            head_op1_nx  = cap_op1;
            head_op2_nx  = cap_op2;
            head_src1_nx = bus.SrcReg1;
            head_src2_nx = bus.SrcReg2;
          end else if (pop) begin
            state_nx = EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            state_nx     = ONE;
            head_op1_nx  = skid_r1;
            head_op2_nx  = skid_r2;
            head_src1_nx = skid_src1;
            head_src2_nx = skid_src2;
          end
        end
        default: state_nx = EMPTY;
      endcase
    end
  end

  // InReady is taken from the next state so upstream never sees a combinational
  // path from OutReady.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= EMPTY;
      in_ready_q <= 1'b1;
      head_op1   <= '0;
      head_op2   <= '0;
      head_src1  <= '0;
      head_src2  <= '0;
      skid_op1   <= '0;
      skid_op2   <= '0;
      skid_src1  <= '0;
      skid_src2  <= '0;
    end else begin
      state      <= state_nx;
      in_ready_q <= (state_nx != TWO);
      head_op1   <= head_op1_nx;
      head_op2   <= head_op2_nx;
      head_src1  <= head_src1_nx;
      head_src2  <= head_src2_nx;
      skid_op1   <= skid_op1_nx;
      skid_op2   <= skid_op2_nx;
      skid_src1  <= skid_src1_nx;
      skid_src2  <= skid_src2_nx;
    end
  end

  assign bus.InReady  = in_ready_q;
  assign bus.RfAddr1  = bus.SrcReg1;
  assign bus.RfAddr2  = bus.SrcReg2;
  assign bus.OutValid = (state != EMPTY);
  assign bus.Op1      = head_op1;
  assign bus.Op2      = head_op2;
  assign bus.OutSrc1  = head_src1;
  assign bus.OutSrc2  = head_src2;

endmodule

// File: tb/tb_operand_read_stage.sv
// Bench for operand_read_stage: directed scenarios plus a random run checked
// against a queue-based model of the operand FIFO and a register-file array.
module tb_operand_read_stage;

  typedef struct {
    logic [15:0] op1;
    logic [15:0] op2;
    logic [3:0]  s1;
    logic [3:0]  s2;
  } ent_t;

  logic        clk;
  logic        rst;
  logic [15:0] regs [16];
  ent_t        mq[$];
  bit          mready;
  int          compared;
  int          mismatched;

  operand_read_stage_if #(.DATA_W(16), .ADDR_W(4)) bus ();

  operand_read_stage #(.DATA_W(16), .ADDR_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.RfData1 = regs[bus.RfAddr1];
  assign bus.RfData2 = regs[bus.RfAddr2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, advance the model, then sample #1 after the edge.
  task automatic step(input bit inv, input logic [3:0] s1, input logic [3:0] s2,
                      input bit wbe, input logic [3:0] wbr, input logic [15:0] wbd,
                      input bit fl, input bit ordy);
    ent_t e;
    bit   acc, pp;
    bus.InValid  = inv;
    bus.SrcReg1  = s1;
    bus.SrcReg2  = s2;
    bus.WbEnable = wbe;
    bus.WbReg    = wbr;
    bus.WbData   = wbd;
    bus.Flush    = fl;
    bus.OutReady = ordy;
    acc = inv && mready;
    pp  = (mq.size() > 0) && ordy;
    if (fl) begin
      mq.delete();
      mready = 1'b1;
    end else begin
      if (pp) void'(mq.pop_front());
`ifdef OPERAND_REFRESH_EN
      foreach (mq[i]) begin
        if (wbe && mq[i].s1 != 0 && mq[i].s1 == wbr) mq[i].op1 = wbd;
        if (wbe && mq[i].s2 != 0 && mq[i].s2 == wbr) mq[i].op2 = wbd;
      end
`endif
      if (acc) begin
        e.s1  = s1;
        e.s2  = s2;
        e.op1 = (s1 == 0) ? 16'h0 : ((wbe && wbr == s1) ? wbd : regs[s1]);
        e.op2 = (s2 == 0) ? 16'h0 : ((wbe && wbr == s2) ? wbd : regs[s2]);
        mq.push_back(e);
      end
      mready = (mq.size() < 2);
    end
    @(posedge clk);
    #1;
    if (wbe) regs[wbr] = wbd;
  endtask

  task automatic idle(input bit ordy);
    step(0, 4'd0, 4'd0, 0, 4'd0, 16'h0, 0, ordy);
  endtask

  task automatic drain();
    repeat (3) idle(1);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.InValid = 0; bus.SrcReg1 = 0; bus.SrcReg2 = 0; bus.WbEnable = 0;
    bus.WbReg = 0; bus.WbData = 0; bus.Flush = 0; bus.OutReady = 0;
    repeat (2) @(posedge clk);
    #1;
    compared++; if (bus.OutValid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_outvalid got %b want 0", bus.OutValid); end
    compared++; if (bus.InReady !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_inready got %b want 1", bus.InReady); end
    compared++; if (bus.Op1 !== 16'h0) begin mismatched++; $display("[TB] FAIL reset_op1 got %h want 0000", bus.Op1); end
    compared++; if (bus.Op2 !== 16'h0) begin mismatched++; $display("[TB] FAIL reset_op2 got %h want 0000", bus.Op2); end
    compared++; if (bus.OutSrc1 !== 4'h0 || bus.OutSrc2 !== 4'h0) begin mismatched++; $display("[TB] FAIL reset_src got %h/%h want 0/0", bus.OutSrc1, bus.OutSrc2); end
    @(negedge clk);
    rst = 1'b1;
    mq.delete();
    mready = 1'b1;
    idle(0);
    idle(0);
    compared++; if (bus.OutValid !== 1'b0 || bus.InReady !== 1'b1) begin mismatched++; $display("[TB] FAIL idle_state got valid=%b ready=%b want 0/1", bus.OutValid, bus.InReady); end
  endtask

  task automatic test_plain_read();
    regs[3] = 16'h1234;
    regs[5] = 16'hBEEF;
    step(1, 4'd3, 4'd5, 0, 4'd0, 16'h0, 0, 1);
    compared++; if (bus.OutValid !== 1'b1) begin mismatched++; $display("[TB] FAIL plain_valid got %b want 1", bus.OutValid); end
    compared++; if (bus.Op1 !== 16'h1234) begin mismatched++; $display("[TB] FAIL plain_op1 got %h want 1234", bus.Op1); end
    compared++; if (bus.Op2 !== 16'hBEEF) begin mismatched++; $display("[TB] FAIL plain_op2 got %h want beef", bus.Op2); end
    compared++; if (bus.OutSrc1 !== 4'd3 || bus.OutSrc2 !== 4'd5) begin mismatched++; $display("[TB] FAIL plain_src got %0d/%0d want 3/5", bus.OutSrc1, bus.OutSrc2); end
    compared++; if (bus.RfAddr1 !== 4'd3 || bus.RfAddr2 !== 4'd5) begin mismatched++; $display("[TB] FAIL plain_rfaddr got %0d/%0d want 3/5", bus.RfAddr1, bus.RfAddr2); end
    idle(1);
    compared++; if (bus.OutValid !== 1'b0) begin mismatched++; $display("[TB] FAIL plain_drained got %b want 0", bus.OutValid); end
  endtask

  task automatic test_bypass();
    regs[7] = 16'h0001;
    regs[2] = 16'h2222;
    step(1, 4'd7, 4'd2, 1, 4'd7, 16'hCAFE, 0, 1);
    compared++; if (bus.Op1 !== 16'hCAFE) begin mismatched++; $display("[TB] FAIL bypass_op1 got %h want cafe", bus.Op1); end
    compared++; if (bus.Op2 !== 16'h2222) begin mismatched++; $display("[TB] FAIL bypass_op2 got %h want 2222", bus.Op2); end
    regs[0] = 16'hFFFF;
    step(1, 4'd7, 4'd0, 1, 4'd0, 16'h1357, 0, 1);
    compared++; if (bus.Op2 !== 16'h0000) begin mismatched++; $display("[TB] FAIL r0_op2 got %h want 0000", bus.Op2); end
    compared++; if (bus.Op1 !== 16'hCAFE || bus.OutValid !== 1'b1) begin mismatched++; $display("[TB] FAIL r0_op1 got %h valid=%b want cafe/1", bus.Op1, bus.OutValid); end
    drain();
  endtask

  task automatic test_back_to_back();
    logic [15:0] a1, b1, b2;
    regs[1] = 16'hA001; regs[2] = 16'hA002; regs[3] = 16'hB003; regs[4] = 16'hB004;
    a1 = regs[1]; b1 = regs[3]; b2 = regs[4];
    step(1, 4'd1, 4'd2, 0, 4'd0, 16'h0, 0, 0);
    compared++; if (bus.InReady !== 1'b1 || bus.Op1 !== a1) begin mismatched++; $display("[TB] FAIL bp_first got ready=%b op1=%h want 1/%h", bus.InReady, bus.Op1, a1); end
    step(1, 4'd3, 4'd4, 0, 4'd0, 16'h0, 0, 0);
    compared++; if (bus.InReady !== 1'b0) begin mismatched++; $display("[TB] FAIL bp_full_ready got %b want 0", bus.InReady); end
    step(1, 4'd5, 4'd6, 0, 4'd0, 16'h0, 0, 0);
    compared++; if (bus.Op1 !== a1 || bus.OutSrc1 !== 4'd1) begin mismatched++; $display("[TB] FAIL bp_head_held got %h src %0d want %h src 1", bus.Op1, bus.OutSrc1, a1); end
    idle(1);
    compared++; if (bus.Op1 !== b1 || bus.Op2 !== b2 || bus.OutSrc1 !== 4'd3) begin mismatched++; $display("[TB] FAIL bp_second got %h/%h src %0d want %h/%h src 3", bus.Op1, bus.Op2, bus.OutSrc1, b1, b2); end
    compared++; if (bus.InReady !== 1'b1) begin mismatched++; $display("[TB] FAIL bp_ready_back got %b want 1", bus.InReady); end
    idle(1);
    compared++; if (bus.OutValid !== 1'b0) begin mismatched++; $display("[TB] FAIL bp_no_c got valid=%b want 0", bus.OutValid); end
  endtask

  task automatic test_refresh();
    logic [15:0] h1, k1, exp_h, exp_k;
    regs[4] = 16'h4444; regs[6] = 16'h6666; regs[9] = 16'h9999; regs[10] = 16'hAAAA;
    h1 = regs[4]; k1 = regs[9];
`ifdef OPERAND_REFRESH_EN
    exp_h = 16'h00AA; exp_k = 16'h5555;
`else
    exp_h = h1; exp_k = k1;
`endif
    step(1, 4'd4, 4'd6, 0, 4'd0, 16'h0, 0, 0);
    step(0, 4'd0, 4'd0, 1, 4'd4, 16'h00AA, 0, 0);
    compared++; if (bus.Op1 !== exp_h) begin mismatched++; $display("[TB] FAIL refresh_head got %h want %h", bus.Op1, exp_h); end
    step(1, 4'd9, 4'd10, 0, 4'd0, 16'h0, 0, 0);
    step(0, 4'd0, 4'd0, 1, 4'd9, 16'h5555, 0, 0);
    idle(1);
    compared++; if (bus.Op1 !== exp_k || bus.OutSrc1 !== 4'd9) begin mismatched++; $display("[TB] FAIL refresh_skid got %h src %0d want %h src 9", bus.Op1, bus.OutSrc1, exp_k); end
    drain();
  endtask

  task automatic test_flush();
    step(1, 4'd1, 4'd2, 0, 4'd0, 16'h0, 0, 0);
    step(1, 4'd3, 4'd4, 0, 4'd0, 16'h0, 0, 0);
    step(1, 4'd5, 4'd6, 0, 4'd0, 16'h0, 1, 1);
    compared++; if (bus.OutValid !== 1'b0 || bus.InReady !== 1'b1) begin mismatched++; $display("[TB] FAIL flush_state got valid=%b ready=%b want 0/1", bus.OutValid, bus.InReady); end
    idle(1);
    compared++; if (bus.OutValid !== 1'b0) begin mismatched++; $display("[TB] FAIL flush_dropped got valid=%b want 0", bus.OutValid); end
  endtask

  task automatic test_reset_mid();
    step(1, 4'd1, 4'd2, 0, 4'd0, 16'h0, 0, 0);
    step(1, 4'd3, 4'd4, 0, 4'd0, 16'h0, 0, 0);
    rst = 1'b0;
    #1;
    compared++; if (bus.OutValid !== 1'b0 || bus.InReady !== 1'b1 || bus.Op1 !== 16'h0) begin mismatched++; $display("[TB] FAIL async_reset got valid=%b ready=%b op1=%h want 0/1/0000", bus.OutValid, bus.InReady, bus.Op1); end
    @(negedge clk);
    rst = 1'b1;
    mq.delete();
    mready = 1'b1;
  endtask

  task automatic test_random();
    bit          inv, wbe, fl, ordy;
    logic [3:0]  s1, s2, wbr;
    logic [15:0] wbd;
    for (int i = 0; i < 400; i++) begin
      inv  = ($urandom_range(0, 3) != 0);
      s1   = 4'($urandom_range(0, 15));
      s2   = 4'($urandom_range(0, 15));
      wbe  = ($urandom_range(0, 1) != 0);
      wbr  = 4'($urandom_range(0, 15));
      wbd  = 16'($urandom);
      fl   = ($urandom_range(0, 24) == 0);
      ordy = ($urandom_range(0, 2) != 0);
      step(inv, s1, s2, wbe, wbr, wbd, fl, ordy);
      compared++; if (bus.OutValid !== 1'(mq.size() > 0)) begin mismatched++; $display("[TB] FAIL rnd_valid[%0d] got %b want %b", i, bus.OutValid, mq.size() > 0); end
      compared++; if (bus.InReady !== mready) begin mismatched++; $display("[TB] FAIL rnd_ready[%0d] got %b want %b", i, bus.InReady, mready); end
      compared++; if (bus.RfAddr1 !== s1 || bus.RfAddr2 !== s2) begin mismatched++; $display("[TB] FAIL rnd_rfaddr[%0d] got %0d/%0d want %0d/%0d", i, bus.RfAddr1, bus.RfAddr2, s1, s2); end
      if (mq.size() > 0) begin
        compared++;
        if (bus.Op1 !== mq[0].op1 || bus.Op2 !== mq[0].op2 || bus.OutSrc1 !== mq[0].s1 || bus.OutSrc2 !== mq[0].s2) begin
          mismatched++;
          $display("[TB] FAIL rnd_head[%0d] got %h/%h src %0d/%0d want %h/%h src %0d/%0d", i,
                   bus.Op1, bus.Op2, bus.OutSrc1, bus.OutSrc2, mq[0].op1, mq[0].op2, mq[0].s1, mq[0].s2);
        end
      end
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    mready     = 1'b1;
    for (int r = 0; r < 16; r++) regs[r] = 16'($urandom);
    test_reset();
    test_plain_read();
    test_bypass();
    test_back_to_back();
    test_refresh();
    test_flush();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/operand_read_stage.md
Name: operand_read_stage

Overview:
Read side of the register file: drives two read addresses, captures the returned operands into a 2-entry skid buffer, and presents them downstream on a valid/ready handshake. Operands are bypassed from the writeback port on capture. Held entries are refreshed when a later write hits their source register. Sits between decode and execute, reading the registers that the writeback path writes through the 4-bit register primitives.

Parameters:
DATA_W, 16, operand width
ADDR_W, 4, register index width (2^ADDR_W registers)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
InValid  in  1  decode presents a read request
InReady  out  1  stage can accept; registered
SrcReg1  in  ADDR_W  source register index 1
SrcReg2  in  ADDR_W  source register index 2
RfAddr1  out  ADDR_W  register file read address 1; equals SrcReg1 (combinational)
RfAddr2  out  ADDR_W  register file read address 2; equals SrcReg2 (combinational)
RfData1  in  DATA_W  register file read data 1 (combinational, same cycle)
RfData2  in  DATA_W  register file read data 2
WbEnable  in  1  writeback write enable
WbReg  in  ADDR_W  writeback destination index
WbData  in  DATA_W  writeback data
Flush  in  1  synchronous discard of all held entries
OutValid  out  1  head entry valid
OutReady  in  1  execute accepts head entry
Op1  out  DATA_W  head operand 1
Op2  out  DATA_W  head operand 2
OutSrc1  out  ADDR_W  head source index 1
OutSrc2  out  ADDR_W  head source index 2

Behaviour:
- Reset (rst=0, async): state EMPTY; OutValid=0, InReady=1, Op1=Op2=0, OutSrc1=OutSrc2=0; skid contents cleared.
- States:
  - EMPTY: no entries.
  - ONE: head valid.
  - TWO: head and skid valid.
- Accept when InValid&InReady. Pop when OutValid&OutReady.
- Transitions:
  - EMPTY + accept -> ONE.
  - ONE + accept + no pop -> TWO.
  - ONE + accept + pop -> ONE (new entry becomes head).
  - ONE + pop only -> EMPTY.
  - TWO + pop -> ONE (skid moves to head).
- InReady is registered: 1 next cycle iff next state != TWO. Accept is never blocked combinationally by OutReady.
- Latency: accepted in cycle N -> visible at Op1/Op2 in cycle N+1 when the stage was empty.
- Capture operand value, per operand:
  - if Src==0: value is 0 (R0 hardwired).
  - else if WbEnable && WbReg==Src: value is WbData (bypass).
  - else: value is RfData.
- Flush: next state EMPTY, OutValid=0, InReady=1. Same-cycle accept is dropped. Flush beats pop and accept.
- A pop while OutReady is high mid-flush is not counted; nothing is consumed.
- Order is preserved; the skid never overtakes the head.
- Asserting rst mid-operation loses all entries. There is no partial state.

Optional Feature:
OPERAND_REFRESH_EN
- Defined: each held entry (head and skid), each operand with Src!=0, is overwritten with WbData on a clock edge where WbEnable && WbReg==Src. Applies in the same cycle as a pop; the popped entry is not refreshed after leaving. Refresh of the skid entry carries over when it moves to head.
- Undefined: held operands are frozen at capture. The hazard unit guarantees no write to a held source.

Test Plan:
- Reset then idle: rst low 2 cycles -> OutValid=0, InReady=1, Op1=Op2=0. Release, no InValid -> state unchanged.
- Plain read: Src1=3, Src2=5, RfData1=0x1234, RfData2=0xBEEF, OutReady=1 -> next cycle OutValid=1, Op1=0x1234, Op2=0xBEEF, OutSrc1=3, OutSrc2=5.
- Bypass and R0:
  - Src1=7, RfData1=0x0001, WbEnable=1, WbReg=7, WbData=0xCAFE -> Op1=0xCAFE.
  - Src2=0, RfData2=0xFFFF, WbReg=0 -> Op2=0.
- Backpressure: OutReady=0, accept A then B -> InReady drops to 0 after B, C is not accepted. Then OutReady=1 -> A, then B, in order. InReady returns to 1 the cycle after the first pop.
- Refresh (OPERAND_REFRESH_EN defined): head Src1=4 held with OutReady=0, write WbReg=4, WbData=0x00AA -> Op1=0x00AA next cycle. With the macro undefined, Op1 keeps its captured value.
- Flush in TWO with InValid=1 and OutReady=1 -> next cycle OutValid=0, InReady=1. The new request is not delivered.
